// File: rtl/cp0_exception_unit.sv
`default_nettype none
// cp0_exception_unit: Status/Cause/EPC holder, exception and interrupt redirect for the ID stage.
// Rev 1.0 - initial release.
module cp0_exception_unit #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [31:0] ID_pc,
  input  logic        undefined,
  input  logic [1:0]  cp0_operation,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  input  logic        int_req,
  output logic [31:0] cp0_rdata,
  output logic        cp0_jump_en,
  output logic [31:0] cp0_jump_addr,
  output logic [31:0] epc_out,
  output logic [31:0] status_out,
  output logic [31:0] cause_out
);

  localparam logic [1:0] OP_MTC0 = 2'b01;
  localparam logic [1:0] OP_ERET = 2'b11;
  localparam logic [4:0] ADDR_STATUS = 5'd12;
  localparam logic [4:0] ADDR_CAUSE  = 5'd13;
  localparam logic [4:0] ADDR_EPC    = 5'd14;
  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_RI  = 5'd10;

  // EXL is the mode bit: NORMAL accepts exceptions, HANDLER blocks nesting.
  typedef enum logic {NORMAL = 1'b0, HANDLER = 1'b1} mode_e;

  mode_e       mode_q, mode_d;
  logic        ie_q, ie_d;
  logic        ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;
  logic        sync1_q, sync2_q, sync3_q;

  logic take_exc, take_int, do_eret, do_mtc0, int_edge, exl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q     <= NORMAL;
      ie_q       <= 1'b0;
      ip_q       <= 1'b0;
      exc_code_q <= 5'd0;
      epc_q      <= 32'd0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      ie_q       <= ie_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
      sync1_q    <= int_req;
      sync2_q    <= sync1_q;
      sync3_q    <= sync2_q;
    end
  end

  always_comb begin
    mode_d        = mode_q;
    ie_d          = ie_q;
    ip_d          = ip_q;
    exc_code_d    = exc_code_q;
    epc_d         = epc_q;
    cp0_jump_en   = 1'b0;
    cp0_jump_addr = 32'd0;

    exl      = (mode_q == HANDLER);
    int_edge = sync2_q & ~sync3_q;
    take_exc = id_valid & ~reset & undefined & ~exl;
    take_int = id_valid & ~reset & ip_q & ie_q & ~exl & ~take_exc;
    // The flushed instruction's own CP0 op never executes when an event is taken.
    do_eret  = id_valid & ~reset & (cp0_operation == OP_ERET) & ~take_exc & ~take_int;
    do_mtc0  = id_valid & ~reset & (cp0_operation == OP_MTC0) & ~take_exc & ~take_int;

    if (take_exc || take_int) begin
      mode_d        = HANDLER;
      epc_d         = ID_pc;
      exc_code_d    = take_exc ? EXC_RI : EXC_INT;
      cp0_jump_en   = 1'b1;
      cp0_jump_addr = HANDLER_ADDR;
    end else if (do_eret) begin
      mode_d        = NORMAL;
      cp0_jump_en   = 1'b1;
      cp0_jump_addr = epc_q;
    end else if (do_mtc0) begin
      if (cp0_addr == ADDR_STATUS) begin
        ie_d   = cp0_wdata[0];
        mode_d = cp0_wdata[1] ? HANDLER : NORMAL;
      end else if (cp0_addr == ADDR_EPC) begin
        epc_d = cp0_wdata;
      end
    end

    // A fresh edge in the take cycle wins over the clear.
    if (take_int) ip_d = 1'b0;
    if (int_edge) ip_d = 1'b1;
  end

  assign status_out = {30'd0, (mode_q == HANDLER), ie_q};
  assign cause_out  = {23'd0, ip_q, 1'b0, exc_code_q, 2'b00};
  assign epc_out    = epc_q;

  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_addr)
      ADDR_STATUS: cp0_rdata = status_out;
      ADDR_CAUSE:  cp0_rdata = cause_out;
      ADDR_EPC:    cp0_rdata = epc_q;
      default:     cp0_rdata = 32'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cp0_exception_unit.sv
`default_nettype none
// tb_cp0_exception_unit: directed and random scoreboard bench for cp0_exception_unit.
module tb_cp0_exception_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] ID_pc;
  logic        undefined;
  logic [1:0]  cp0_operation;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic        int_req;
  logic [31:0] cp0_rdata, cp0_jump_addr, epc_out, status_out, cause_out;
  logic        cp0_jump_en;

  cp0_exception_unit #(.HANDLER_ADDR(32'h0000_0008)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .ID_pc(ID_pc),
    .undefined(undefined), .cp0_operation(cp0_operation), .cp0_addr(cp0_addr),
    .cp0_wdata(cp0_wdata), .int_req(int_req), .cp0_rdata(cp0_rdata),
    .cp0_jump_en(cp0_jump_en), .cp0_jump_addr(cp0_jump_addr),
    .epc_out(epc_out), .status_out(status_out), .cause_out(cause_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic        jen;
    logic [31:0] jaddr, rdata, status, cause, epc;
  } exp_t;
  exp_t sb_q[$];

  // Reference state
  logic       m_ie, m_exl, m_ip, m_s1, m_s2, m_s3;
  logic [4:0] m_exc;
  logic [31:0] m_epc;

  task automatic model_reset();
    m_ie = 0; m_exl = 0; m_ip = 0; m_s1 = 0; m_s2 = 0; m_s3 = 0; m_exc = 0; m_epc = 0;
  endtask

  function automatic logic [31:0] m_status(); return {30'd0, m_exl, m_ie}; endfunction
  function automatic logic [31:0] m_cause();  return {23'd0, m_ip, 1'b0, m_exc, 2'b00}; endfunction

  // One ID cycle: drive, predict, compare at negedge, advance model, return at posedge+1.
  task automatic step(input logic v, input logic [31:0] pc, input logic undef,
                      input logic [1:0] op, input logic [4:0] addr,
                      input logic [31:0] wd, input logic irq);
    exp_t e;
    logic exc_t, int_t, eret_t, mtc_t, edge_t;
    id_valid = v; ID_pc = pc; undefined = undef; cp0_operation = op;
    cp0_addr = addr; cp0_wdata = wd; int_req = irq;

    exc_t  = v & undef & ~m_exl;
    int_t  = v & m_ip & m_ie & ~m_exl & ~exc_t;
    eret_t = v & (op == 2'b11) & ~exc_t & ~int_t;
    mtc_t  = v & (op == 2'b01) & ~exc_t & ~int_t;
    edge_t = m_s2 & ~m_s3;

    e.jen    = exc_t | int_t | eret_t;
    e.jaddr  = (exc_t | int_t) ? 32'h8 : (eret_t ? m_epc : 32'h0);
    e.status = m_status();
    e.cause  = m_cause();
    e.epc    = m_epc;
    case (addr)
      5'd12:   e.rdata = m_status();
      5'd13:   e.rdata = m_cause();
      5'd14:   e.rdata = m_epc;
      default: e.rdata = 32'h0;
    endcase
    sb_q.push_back(e);

    @(negedge clk);
    e = sb_q.pop_front();
    check("jump_en",   {31'd0, cp0_jump_en}, {31'd0, e.jen});
    check("jump_addr", cp0_jump_addr, e.jaddr);
    check("rdata",     cp0_rdata, e.rdata);
    check("status",    status_out, e.status);
    check("cause",     cause_out, e.cause);
    check("epc",       epc_out, e.epc);

    if (exc_t || int_t) begin
      m_exl = 1; m_epc = pc; m_exc = exc_t ? 5'd10 : 5'd0;
    end else if (eret_t) begin
      m_exl = 0;
    end else if (mtc_t) begin
      if (addr == 5'd12) begin m_ie = wd[0]; m_exl = wd[1]; end
      else if (addr == 5'd14) m_epc = wd;
    end
    if (int_t) m_ip = 0;
    if (edge_t) m_ip = 1;
    m_s3 = m_s2; m_s2 = m_s1; m_s1 = irq;

    @(posedge clk);
    #1;
  endtask

  task automatic nop(input logic v, input logic irq);
    step(v, 32'h100, 1'b0, 2'b00, 5'd0, 32'h0, irq);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] rop;
    logic [4:0] raddr;
    logic       rirq;
    model_reset();
    reset = 1'b1; id_valid = 1'b1; ID_pc = 32'h44; undefined = 1'b1;
    cp0_operation = 2'b11; cp0_addr = 5'd12; cp0_wdata = 32'h0; int_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_jump_en",   {31'd0, cp0_jump_en}, 32'd0);
    check("rst_jump_addr", cp0_jump_addr, 32'd0);
    check("rst_status",    status_out, 32'd0);
    check("rst_epc",       epc_out, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // mfc0 of each register after reset
    step(1, 32'h0, 0, 2'b10, 5'd12, 0, 0);
    step(1, 32'h4, 0, 2'b10, 5'd13, 0, 0);
    step(1, 32'h8, 0, 2'b10, 5'd14, 0, 0);

    // IE=1, raise interrupt while ID is stalled; take deferred until valid
    step(1, 32'hC, 0, 2'b01, 5'd12, 32'h1, 0);
    check("ie_set", status_out, 32'h1);
    repeat (4) nop(0, 1);
    check("ip_pending", cause_out, 32'h100);
    // flushed mtc0 to EPC must not land
    step(1, 32'h40, 0, 2'b01, 5'd14, 32'hDEAD_BEEF, 1);
    check("int_epc",    epc_out, 32'h40);
    check("int_status", status_out, 32'h3);
    check("int_cause",  cause_out, 32'h0);

    // eret back to 0x40
    step(1, 32'h50, 0, 2'b11, 5'd0, 0, 1);
    check("eret_status", status_out, 32'h1);

    // reserved instruction with IE=0
    step(1, 32'h40, 0, 2'b01, 5'd12, 32'h0, 1);
    step(1, 32'h24, 1, 2'b00, 5'd0, 0, 1);
    check("ri_epc",   epc_out, 32'h24);
    check("ri_cause", cause_out, 32'h28);

    // undefined in handler is a nop; interrupt edge held off by EXL
    step(1, 32'h8, 1, 2'b00, 5'd0, 0, 0);
    check("ri_nested_epc", epc_out, 32'h24);
    nop(1, 0);
    repeat (4) nop(1, 1);
    check("held_ip", cause_out[8], 1'b1);
    step(1, 32'h10, 0, 2'b01, 5'd12, 32'h3, 1);
    step(1, 32'h14, 0, 2'b11, 5'd0, 0, 1);
    step(1, 32'h24, 0, 2'b00, 5'd0, 0, 1);
    check("held_take_epc", epc_out, 32'h24);

    // new edge in handler, eret, then undefined with IP and IE
    repeat (2) nop(1, 0);
    repeat (4) nop(1, 1);
    step(1, 32'h14, 0, 2'b11, 5'd0, 0, 1);
    step(1, 32'h60, 1, 2'b00, 5'd0, 0, 1);
    check("simul_cause", cause_out, 32'h128);
    check("simul_epc",   epc_out, 32'h60);

    // random traffic against the model
    for (int i = 0; i < 200; i++) begin
      rop   = 2'($urandom_range(0, 3));
      raddr = ($urandom_range(0, 3) == 0) ? 5'd5 : 5'(12 + $urandom_range(0, 2));
      rirq  = ($urandom_range(0, 5) == 0) ? ~int_req : int_req;
      step(1'($urandom_range(0, 3) != 0), $urandom & 32'hFFFF_FFFC,
           ($urandom_range(0, 7) == 0), rop, raddr, $urandom, rirq);
    end

    // enter handler, then asynchronous reset mid-handler
    step(1, 32'h70, 1, 2'b00, 5'd0, 0, int_req);
    if (status_out[1] !== 1'b1) step(1, 32'h74, 0, 2'b01, 5'd12, 32'h2, int_req);
    #3;
    reset = 1'b1;
    #1;
    check("async_rst_epc",    epc_out, 32'd0);
    check("async_rst_status", status_out, 32'd0);
    check("async_rst_cause",  cause_out, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
